// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV pixel sequencer: FSM encoding, hue sector codes
// and the 8-bit to 2.16 fixed-point conversion used on the selector r/g/b bus.
package hsv_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DIV_S   = 3'd3;
    localparam logic [2:0] ST_DIV_H   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [2:0] SECT_000 = 3'b000;
    localparam logic [2:0] SECT_001 = 3'b001;
    localparam logic [2:0] SECT_011 = 3'b011;
    localparam logic [2:0] SECT_100 = 3'b100;
    localparam logic [2:0] SECT_110 = 3'b110;
    localparam logic [2:0] SECT_111 = 3'b111;
    localparam logic [2:0] SECT_ERR = 3'b010;

    // {R,R} scaled by 2^-16 is R*257/65536, which is within rounding of R/255.
    function automatic logic [17:0] to_2p16(input logic [7:0] c);
        return {2'b00, c, c};
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 fraction divider: q = floor(num*2^QW/den), saturating at num>=den, 0 for den==0.
// One load edge plus QW iteration edges; done pulses with the final iteration; start is ignored while busy.
module seq_divider #(
    parameter int DW = 18,
    parameter int QW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [DW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] q
);

    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] rem;
    logic [DW-1:0] dvs;
    logic [QW-1:0] qacc;
    logic [CW-1:0] cnt;
    logic          sat;
    logic          zero;
    logic [DW:0]   rem_sh;
    logic          ge;
    logic [DW-1:0] rem_nxt;

    assign rem_sh  = {rem, 1'b0};
    assign ge      = (rem_sh >= {1'b0, dvs});
    assign rem_nxt = ge ? DW'(rem_sh - {1'b0, dvs}) : DW'(rem_sh);

    // Special cases are resolved at load time so the iteration count never varies.
    assign q = zero ? '0 : (sat ? '1 : qacc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rem  <= '0;
            dvs  <= '0;
            qacc <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
            zero <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem  <= num;
                dvs  <= den;
                qacc <= '0;
                cnt  <= CW'(QW);
                sat  <= (den != '0) && (num >= den);
                zero <= (den == '0);
                busy <= 1'b1;
            end else if (busy) begin
                rem  <= rem_nxt;
                qacc <= {qacc[QW-2:0], ge};
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hsv_pixel_sequencer.sv
// Pixel controller around max_min_selector; one shared divider yields S then H_FRAC, result after 2+2*(QW+1) edges.
// One pixel in flight: pix_ready only in IDLE, hsv_valid held with stable outputs until hsv_ready.
module hsv_pixel_sequencer
    import hsv_pkg::*;
#(
    parameter int QW = 8,
    parameter int DW = 18
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [7:0]    pix_R,
    input  logic [7:0]    pix_G,
    input  logic [7:0]    pix_B,
    output logic [7:0]    sel_R,
    output logic [7:0]    sel_G,
    output logic [7:0]    sel_B,
    output logic [DW-1:0] sel_r,
    output logic [DW-1:0] sel_g,
    output logic [DW-1:0] sel_b,
    input  logic [DW-1:0] sel_max_min,
    input  logic [DW-1:0] sel_TOP,
    input  logic [7:0]    sel_D,
    input  logic [7:0]    sel_MAX,
    input  logic [2:0]    sel_RGB_SE,
    output logic          hsv_valid,
    input  logic          hsv_ready,
    output logic [2:0]    H_SECT,
    output logic [QW-1:0] H_FRAC,
    output logic [QW-1:0] S,
    output logic [7:0]    V,
    output logic          err
);

    logic [2:0]    state;
    logic [DW-1:0] cap_mm;
    logic [DW-1:0] cap_top;
    logic          div_start;
    logic          div_busy;
    logic          div_done;
    logic [DW-1:0] div_num;
    logic [DW-1:0] div_den;
    logic [QW-1:0] div_q;
    logic          sel_is_err;

    assign sel_is_err = (sel_RGB_SE == SECT_ERR);

    // Saturation divide launches from the live selector outputs; hue divide from the captured pair.
    assign div_start = !div_busy && ((state == ST_CAPTURE) || ((state == ST_DIV_S) && div_done));
    assign div_num   = (state == ST_CAPTURE) ? DW'(sel_D)   : cap_top;
    assign div_den   = (state == ST_CAPTURE) ? DW'(sel_MAX) : cap_mm;

    seq_divider #(.DW(DW), .QW(QW)) u_div (
        .CLK   (CLK),
        .RST   (RST),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            pix_ready <= 1'b0;
            hsv_valid <= 1'b0;
            sel_R     <= '0;
            sel_G     <= '0;
            sel_B     <= '0;
            sel_r     <= '0;
            sel_g     <= '0;
            sel_b     <= '0;
            cap_mm    <= '0;
            cap_top   <= '0;
            H_SECT    <= '0;
            H_FRAC    <= '0;
            S         <= '0;
            V         <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pix_ready <= 1'b1;
                    if (pix_valid && pix_ready) begin
                        pix_ready <= 1'b0;
                        sel_R     <= pix_R;
                        sel_G     <= pix_G;
                        sel_B     <= pix_B;
                        sel_r     <= DW'(to_2p16(pix_R));
                        sel_g     <= DW'(to_2p16(pix_G));
                        sel_b     <= DW'(to_2p16(pix_B));
                        err       <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    cap_mm  <= sel_max_min;
                    cap_top <= sel_TOP;
                    H_SECT  <= sel_RGB_SE;
                    err     <= sel_is_err;
                    V       <= sel_is_err ? 8'd0 : sel_MAX;
                    state   <= ST_DIV_S;
                end
                ST_DIV_S: begin
                    if (div_done) begin
                        S     <= err ? '0 : div_q;
                        state <= ST_DIV_H;
                    end
                end
                ST_DIV_H: begin
                    if (div_done) begin
                        H_FRAC    <= err ? '0 : div_q;
                        hsv_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (hsv_ready) begin
                        hsv_valid <= 1'b0;
                        pix_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pix_ready <= 1'b0;
                    hsv_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_pixel_sequencer.sv
// Directed bench for hsv_pixel_sequencer with a registered max_min_selector stand-in.
module tb_hsv_pixel_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_R, pix_G, pix_B;
    logic [7:0]  sel_R, sel_G, sel_B;
    logic [17:0] sel_r, sel_g, sel_b;
    logic [17:0] sel_max_min, sel_TOP;
    logic [7:0]  sel_D, sel_MAX;
    logic [2:0]  sel_RGB_SE;
    logic        hsv_valid;
    logic        hsv_ready;
    logic [2:0]  H_SECT;
    logic [7:0]  H_FRAC, S, V;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc;
    int lat;

    // TOP and sector code are set per test; MAX, D and max_min follow the DUT's sel_* outputs.
    logic [17:0] model_top = '0;
    logic [2:0]  model_se  = 3'b111;

    hsv_pixel_sequencer #(.QW(8), .DW(18)) dut (
        .CLK(CLK), .RST(RST),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
        .sel_R(sel_R), .sel_G(sel_G), .sel_B(sel_B),
        .sel_r(sel_r), .sel_g(sel_g), .sel_b(sel_b),
        .sel_max_min(sel_max_min), .sel_TOP(sel_TOP), .sel_D(sel_D),
        .sel_MAX(sel_MAX), .sel_RGB_SE(sel_RGB_SE),
        .hsv_valid(hsv_valid), .hsv_ready(hsv_ready),
        .H_SECT(H_SECT), .H_FRAC(H_FRAC), .S(S), .V(V), .err(err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] max3(input logic [7:0] a, b, c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [7:0] min3(input logic [7:0] a, b, c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    always @(posedge CLK) begin
        sel_MAX     <= max3(sel_R, sel_G, sel_B);
        sel_D       <= max3(sel_R, sel_G, sel_B) - min3(sel_R, sel_G, sel_B);
        sel_max_min <= {2'b00, max3(sel_R, sel_G, sel_B), max3(sel_R, sel_G, sel_B)}
                     - {2'b00, min3(sel_R, sel_G, sel_B), min3(sel_R, sel_G, sel_B)};
        sel_TOP     <= model_top;
        sel_RGB_SE  <= model_se;
    end

    task automatic send(input logic [7:0] r, g, b);
        int n = 0;
        while (!pix_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!pix_ready) begin
            failures++;
            $display("FAIL send_ready_timeout pix_ready=%0b required=1", pix_ready);
        end
        pix_valid = 1'b1;
        pix_R = r; pix_G = g; pix_B = b;
        @(negedge CLK);
        acc_cyc   = cyc;
        pix_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!hsv_valid && n < 60) begin
            @(negedge CLK);
            n++;
        end
        lat = cyc - acc_cyc;
        checks++;
        if (!hsv_valid) begin
            failures++;
            $display("FAIL hsv_valid_timeout hsv_valid=%0b required=1", hsv_valid);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; pix_valid = 1'b0; hsv_ready = 1'b0;
        pix_R = '0; pix_G = '0; pix_B = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({pix_ready, hsv_valid, S, H_FRAC, V, H_SECT, err, sel_r} !== '0) begin
            failures++;
            $display("FAIL reset_outputs pix_ready=%0b hsv_valid=%0b S=%0d H=%0d V=%0d sel_r=%h required all 0",
                     pix_ready, hsv_valid, S, H_FRAC, V, sel_r);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready pix_ready=%0b required=1", pix_ready);
        end
    endtask

    task automatic test_single();
        model_top = 18'h05555; model_se = 3'b111; hsv_ready = 1'b1;
        send(8'd200, 8'd100, 8'd50);
        checks++;
        if (sel_r !== 18'h0C8C8 || sel_g !== 18'h06464 || sel_b !== 18'h03232) begin
            failures++;
            $display("FAIL single_sel_rgb sel_r=%h sel_g=%h sel_b=%h required 0c8c8 06464 03232", sel_r, sel_g, sel_b);
        end
        wait_valid();
        checks++;
        if (lat !== 20) begin
            failures++;
            $display("FAIL single_latency got=%0d required=20", lat);
        end
        checks++;
        if (S !== 8'd192 || H_FRAC !== 8'd145) begin
            failures++;
            $display("FAIL single_s_h S=%0d H_FRAC=%0d required 192 145", S, H_FRAC);
        end
        checks++;
        if (V !== 8'd200 || H_SECT !== 3'b111 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_v_sect V=%0d H_SECT=%b err=%0b required 200 111 0", V, H_SECT, err);
        end
        @(negedge CLK);
        checks++;
        if (hsv_valid !== 1'b0 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_handoff hsv_valid=%0b pix_ready=%0b required 0 1", hsv_valid, pix_ready);
        end
    endtask

    task automatic test_gray_black();
        model_top = '0; model_se = 3'b000; hsv_ready = 1'b1;
        send(8'd77, 8'd77, 8'd77);
        wait_valid();
        checks++;
        if (lat !== 20 || S !== 8'd0 || H_FRAC !== 8'd0 || V !== 8'd77 || err !== 1'b0) begin
            failures++;
            $display("FAIL gray lat=%0d S=%0d H=%0d V=%0d err=%0b required 20 0 0 77 0", lat, S, H_FRAC, V, err);
        end
        @(negedge CLK);
        send(8'd0, 8'd0, 8'd0);
        wait_valid();
        checks++;
        if (lat !== 20 || S !== 8'd0 || H_FRAC !== 8'd0 || V !== 8'd0) begin
            failures++;
            $display("FAIL black lat=%0d S=%0d H=%0d V=%0d required 20 0 0 0", lat, S, H_FRAC, V);
        end
        @(negedge CLK);
    endtask

    task automatic test_saturation();
        model_top = '0; model_se = 3'b111; hsv_ready = 1'b1;
        send(8'd255, 8'd0, 8'd0);
        wait_valid();
        checks++;
        if (S !== 8'd255 || H_FRAC !== 8'd0 || V !== 8'd255) begin
            failures++;
            $display("FAIL saturation S=%0d H=%0d V=%0d required 255 0 255", S, H_FRAC, V);
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        model_top = 18'h05555; model_se = 3'b111; hsv_ready = 1'b0;
        send(8'd200, 8'd100, 8'd50);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (hsv_valid !== 1'b1 || pix_ready !== 1'b0 || S !== 8'd192 || H_FRAC !== 8'd145 || V !== 8'd200)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL backpressure_hold bad_cycles=%0d required=0", bad);
        end
        hsv_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (hsv_valid !== 1'b0 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release hsv_valid=%0b pix_ready=%0b required 0 1", hsv_valid, pix_ready);
        end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        model_top = 18'h05555; model_se = 3'b111; hsv_ready = 1'b1;
        send(8'd200, 8'd100, 8'd50);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({pix_ready, hsv_valid, S, H_FRAC, V, H_SECT, err} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs pix_ready=%0b hsv_valid=%0b S=%0d H=%0d V=%0d sect=%b err=%0b required all 0",
                     pix_ready, hsv_valid, S, H_FRAC, V, H_SECT, err);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (hsv_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midop_no_result valid_cycles=%0d required=0", seen);
        end
        model_top = '0;
        send(8'd255, 8'd0, 8'd0);
        wait_valid();
        checks++;
        if (lat !== 20 || S !== 8'd255 || V !== 8'd255 || H_FRAC !== 8'd0) begin
            failures++;
            $display("FAIL midop_next_pixel lat=%0d S=%0d V=%0d H=%0d required 20 255 255 0", lat, S, V, H_FRAC);
        end
        @(negedge CLK);
    endtask

    task automatic test_error();
        model_top = 18'h05555; model_se = 3'b010; hsv_ready = 1'b1;
        send(8'd200, 8'd100, 8'd50);
        wait_valid();
        checks++;
        if (lat !== 20 || err !== 1'b1 || H_SECT !== 3'b010) begin
            failures++;
            $display("FAIL error_flag lat=%0d err=%0b H_SECT=%b required 20 1 010", lat, err, H_SECT);
        end
        checks++;
        if (S !== 8'd0 || H_FRAC !== 8'd0 || V !== 8'd0) begin
            failures++;
            $display("FAIL error_zeroed S=%0d H=%0d V=%0d required 0 0 0", S, H_FRAC, V);
        end
        @(negedge CLK);
        model_se = 3'b111; model_top = '0;
        send(8'd77, 8'd77, 8'd77);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL error_clear_on_accept err=%0b required=0", err);
        end
        wait_valid();
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_gray_black();
        test_saturation();
        test_backpressure();
        test_reset_midop();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
